number_tx: RTL and testbench
============================

NUMBER_TX -- requirements
Module: number_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1085, clock cycles per UART bit (115200 baud at 125 MHz).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port number  input  16  value to print, sampled only on acceptance.
REQ-005 SHALL have port number_valid  input  1  request to print number.
REQ-006 SHALL have port ready  output  1  high when idle and able to accept a request.
REQ-007 SHALL have port tx_out  output  1  UART serial line, idle high.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the final stop bit of a message.

Function
REQ-009 SHALL accept a request on a rising edge where ready=1 and number_valid=1, capture number, and drive ready=0 from the next cycle.
REQ-010 SHALL ignore number_valid while ready=0, with no queuing.
REQ-011 SHALL convert the captured value to decimal by repeated subtraction of 10000, 1000, 100, 10 and 1, one subtraction per cycle, storing up to 5 ASCII digits ("0"=0x30).
REQ-012 SHALL suppress leading zeros; value 0 SHALL emit the single digit "0".
REQ-013 SHALL transmit digits most-significant first, followed by line feed 0x0A.
REQ-014 SHALL use UART frames of 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-015 SHALL send frames back-to-back with no idle gap between stop bit and next start bit.
REQ-016 SHALL begin the first start bit no more than 64 cycles after acceptance.
REQ-017 SHALL use states IDLE -> CONVERT -> START -> DATA -> STOP, then START for the next character or DONE after 0x0A, then IDLE.
REQ-018 SHALL pulse done for one cycle in DONE, and SHALL assert ready in that same cycle.
REQ-019 SHALL hold tx_out=1 in IDLE, CONVERT and DONE.
REQ-020 SHALL use a bit counter that counts 0..CLKS_PER_BIT-1 and a data-bit index that counts 0..7, each wrapping to 0 on frame or bit change.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-frame, immediately force state IDLE, tx_out=1, ready=1, done=0, clear all counters and the digit buffer, and abort any message.
REQ-022 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL, when SIGNED_EN is defined, treat number as two's complement; for a negative value it SHALL emit "-" (0x2D) first, then the magnitude digits (0x8000 prints "-32768"), with the start-bit bound of REQ-016 unchanged.
REQ-024 SHALL, when SIGNED_EN is undefined, treat number as unsigned 0..65535 and never emit "-".

Verification
REQ-025 SHALL verify: number=12 -> bytes 0x31,0x32,0x0A on tx_out; each bit 1085 cycles; one done pulse; ready=1 afterwards.
REQ-026 SHALL verify: number=0 -> 0x30,0x0A; number=65535 (unsigned build) -> 0x36,0x35,0x35,0x33,0x35,0x0A.
REQ-027 SHALL verify: with SIGNED_EN, 0xFFF4 -> 0x2D,0x31,0x32,0x0A; 0x8000 -> 0x2D,0x33,0x32,0x37,0x36,0x38,0x0A.
REQ-028 SHALL verify: number_valid pulsed with number=99 while printing 12 -> only "12\n" is emitted and exactly one done pulse occurs.
REQ-029 SHALL verify: rst_n low during the data bits of the second character -> tx_out=1 and ready=1 immediately; a subsequent request for 7 -> 0x37,0x0A.
REQ-030 SHALL verify: loop tx_out into uart_rx -> uart_rx recovers the same byte sequence, and feeding that through digits_to_byte returns the original value.

Source files
------------

// File: rtl/number_tx.sv
// number_tx: prints a captured 16-bit value as decimal ASCII digits plus LF on a UART line.
// Build option SIGNED_EN: the value is two's complement and negatives get a leading '-'.
module number_tx #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] number,
  input  logic        number_valid,
  output logic        ready,
  output logic        tx_out,
  output logic        done
);

  // state   | meaning
  // IDLE    | line idle, waiting for a request
  // CONVERT | binary to decimal, one subtraction per cycle
  // START   | start bit of the current character
  // DATA    | 8 data bits, LSB first
  // STOP    | stop bit; then next character or DONE
  // DONE    | one-cycle done pulse, already ready for a new request
  typedef enum logic [2:0] {IDLE, CONVERT, START, DATA, STOP, DONE} state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  state_t          state, state_nxt;
  logic [15:0]     rem;
  logic [15:0]     pow;
  logic [2:0]      pos;
  logic [3:0]      digit_val;
  logic            started;
  logic [7:0]      char_buf [0:7];
  logic [2:0]      wr_ptr;
  logic [2:0]      rd_ptr;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      cur_char;
  logic            accept;
  logic            sub_ok;
  logic            bit_end;
  logic            last_char;

  always_comb begin
    case (pos)
      3'd0:    pow = 16'd10000;
      3'd1:    pow = 16'd1000;
      3'd2:    pow = 16'd100;
      3'd3:    pow = 16'd10;
      default: pow = 16'd1;
    endcase
  end

  assign accept    = ready & number_valid;
  assign sub_ok    = (rem >= pow);
  assign bit_end   = (bit_cnt == BIT_LAST);
  // The line feed is never stored: it is sent once the read pointer reaches the write pointer.
  assign last_char = (rd_ptr == wr_ptr);
  assign cur_char  = last_char ? 8'h0A : char_buf[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    tx_out    = 1'b1;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (number_valid) state_nxt = CONVERT;
      end
      CONVERT: begin
        if (!sub_ok && pos == 3'd4) state_nxt = START;
      end
      START: begin
        tx_out = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_out = cur_char[bit_idx];
        if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) state_nxt = last_char ? DONE : START;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        state_nxt = number_valid ? CONVERT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= 16'd0;
      pos       <= 3'd0;
      digit_val <= 4'd0;
      started   <= 1'b0;
      wr_ptr    <= 3'd0;
      rd_ptr    <= 3'd0;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      for (int i = 0; i < 8; i++) char_buf[i] <= 8'h00;
    end else begin
      if (accept) begin
        pos       <= 3'd0;
        digit_val <= 4'd0;
        started   <= 1'b0;
        rd_ptr    <= 3'd0;
`ifdef SIGNED_EN
        if (number[15]) begin
          rem         <= 16'd0 - number;
          char_buf[0] <= 8'h2D;
          wr_ptr      <= 3'd1;
        end else begin
          rem    <= number;
          wr_ptr <= 3'd0;
        end
`else
        rem    <= number;
        wr_ptr <= 3'd0;
`endif
      end
      case (state)
        CONVERT: begin
          if (sub_ok) begin
            rem       <= rem - pow;
            digit_val <= digit_val + 4'd1;
          end else begin
            // Leading zeros are dropped; the units digit is always kept so 0 prints "0".
            if (digit_val != 4'd0 || started || pos == 3'd4) begin
              char_buf[wr_ptr] <= {4'h3, digit_val};
              wr_ptr           <= wr_ptr + 3'd1;
              started          <= 1'b1;
            end
            digit_val <= 4'd0;
            if (pos != 3'd4) pos <= pos + 3'd1;
          end
        end
        START: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
        end
        DATA: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
          if (bit_end) bit_idx <= bit_idx + 3'd1;
        end
        STOP: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
          if (bit_end && !last_char) rd_ptr <= rd_ptr + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_number_tx.sv
// tb_number_tx: directed requests with hand-computed byte streams; a UART monitor
// decodes tx_out and checks each frame against a scoreboard queue.
module tb_number_tx;

  localparam int CPB = 25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] number = 16'd0;
  logic        number_valid = 1'b0;
  logic        ready;
  logic        tx_out;
  logic        done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_dones = 0;
  logic [7:0] exp_bytes[$];
  int         exp_vals[$];

  number_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .number(number), .number_valid(number_valid),
    .ready(ready), .tx_out(tx_out), .done(done)
  );

  always #5 clk = ~clk;

  initial begin : done_counter
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
    end
  end

  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] b, exp_b;
    logic [7:0] msg[$];
    bit stable, aborted, have_start, neg;
    int v;
    have_start = 1'b0;
    forever begin
      if (!have_start) begin
        @(negedge clk);
        if (!(rst_n === 1'b1 && tx_out === 1'b0)) continue;
      end
      have_start = 1'b0;
      stable = 1'b1;
      aborted = 1'b0;
      bits = '0;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < CPB; c++) begin
          if (k > 0 || c > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
          if (c == 0) bits[k] = tx_out;
          else if (tx_out !== bits[k]) stable = 1'b0;
        end
        if (aborted) break;
      end
      if (aborted) begin msg.delete(); continue; end
      b = bits[8:1];
      tests++;
      if (exp_bytes.size() == 0) begin
        fails++;
        $display("FAIL unexpected_byte got %h expected none", b);
      end else begin
        exp_b = exp_bytes.pop_front();
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || !stable || b !== exp_b) begin
          fails++;
          $display("FAIL frame got byte %h start %b stop %b stable %b expected byte %h start 0 stop 1 stable 1",
                   b, bits[0], bits[9], stable, exp_b);
        end
      end
      msg.push_back(b);
      @(negedge clk);
      if (b == 8'h0A) begin
        tests++;
        if (done !== 1'b1 || ready !== 1'b1) begin
          fails++;
          $display("FAIL done_after_lf got done=%b ready=%b expected 1 1", done, ready);
        end
        v = 0;
        neg = 1'b0;
        foreach (msg[i]) begin
          if (i == 0 && msg[i] == 8'h2D) neg = 1'b1;
          else if (msg[i] != 8'h0A) v = v * 10 + int'(msg[i] - 8'h30);
        end
        if (neg) v = -v;
        tests++;
        if (exp_vals.size() == 0) begin
          fails++;
          $display("FAIL roundtrip_value got %0d expected no message", v);
        end else begin
          int ev;
          ev = exp_vals.pop_front();
          if (v != ev) begin
            fails++;
            $display("FAIL roundtrip_value got %0d expected %0d", v, ev);
          end
        end
        msg.delete();
      end else if (rst_n === 1'b1) begin
        tests++;
        if (tx_out !== 1'b0) begin
          fails++;
          $display("FAIL back_to_back got tx_out=%b expected 0", tx_out);
        end else have_start = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic got, input logic expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got %b expected %b", name, got, expv);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    if (ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL wait_ready timeout got ready=%b expected 1", ready);
    end
  endtask

  task automatic send(input logic [15:0] n, input logic [55:0] exp, input int cnt,
                      input int val, input bit from_reset);
    int lat;
    for (int i = 0; i < cnt; i++) exp_bytes.push_back(exp[8*(cnt-1-i) +: 8]);
    exp_vals.push_back(val);
    exp_dones++;
    if (!from_reset) wait_ready();
    number = n;
    number_valid = 1'b1;
    if (from_reset) begin @(negedge clk); rst_n = 1'b1; end
    @(posedge clk);
    #1 number_valid = 1'b0;
    check("ready_low_after_accept", ready, 1'b0);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (tx_out === 1'b0) break;
    end
    tests++;
    if (tx_out !== 1'b0 || lat > 64) begin
      fails++;
      $display("FAIL start_latency got %0d cycles expected <= 64", lat);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < budget);
    if (done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL wait_done timeout got done=%b expected 1", done);
    end
    repeat (2) @(negedge clk);
    check("ready_after_done", ready, 1'b1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin : stimulus
    bit saw_low;
    repeat (3) @(negedge clk);
    check("reset_tx_out", tx_out, 1'b1);
    check("reset_ready", ready, 1'b1);
    check("reset_done", done, 1'b0);

    // Request held during reset is taken on the first edge after release.
    send(16'd0, {8'h30, 8'h0A}, 2, 0, 1'b1);
    wait_done(8 * 10 * CPB + 200);

    // 99 requested mid-message must be dropped.
    send(16'd12, {8'h31, 8'h32, 8'h0A}, 3, 12, 1'b0);
    check("ready_low_while_busy", ready, 1'b0);
    number = 16'd99;
    number_valid = 1'b1;
    @(posedge clk);
    #1 number_valid = 1'b0;
    wait_done(8 * 10 * CPB + 200);
    saw_low = 1'b0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (tx_out !== 1'b1) saw_low = 1'b1;
    end
    check("no_queued_request", saw_low, 1'b0);
    tests++;
    if (done_cnt != exp_dones) begin
      fails++;
      $display("FAIL done_count_mid got %0d expected %0d", done_cnt, exp_dones);
    end

`ifdef SIGNED_EN
    send(16'hFFF4, {8'h2D, 8'h31, 8'h32, 8'h0A}, 4, -12, 1'b0);
    wait_done(8 * 10 * CPB + 200);
    send(16'h8000, {8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38, 8'h0A}, 7, -32768, 1'b0);
    wait_done(8 * 10 * CPB + 200);
`else
    send(16'hFFFF, {8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0A}, 6, 65535, 1'b0);
    wait_done(8 * 10 * CPB + 200);
    send(16'h8000, {8'h33, 8'h32, 8'h37, 8'h36, 8'h38, 8'h0A}, 6, 32768, 1'b0);
    wait_done(8 * 10 * CPB + 200);
`endif

    // Reset while the data bits of the second character are on the line.
    send(16'd345, {8'h33, 8'h34, 8'h35, 8'h0A}, 4, 345, 1'b0);
    repeat (13 * CPB) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_bytes.delete();
    exp_vals.delete();
    exp_dones--;
    #1;
    check("midframe_reset_tx_out", tx_out, 1'b1);
    check("midframe_reset_ready", ready, 1'b1);
    check("midframe_reset_done", done, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send(16'd7, {8'h37, 8'h0A}, 2, 7, 1'b0);
    wait_done(8 * 10 * CPB + 200);

    repeat (5) @(negedge clk);
    tests++;
    if (exp_bytes.size() != 0 || exp_vals.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected got %0d bytes %0d values expected 0 0",
               exp_bytes.size(), exp_vals.size());
    end
    tests++;
    if (done_cnt != exp_dones) begin
      fails++;
      $display("FAIL done_count got %0d expected %0d", done_cnt, exp_dones);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
